wb_burst_master: RTL and testbench

Wishbone initiator that converts a simple command/data stream into Wishbone classic and incrementing-burst cycles toward the SDRAM controller's Wishbone slave port. It drives `wb_cyc_i`/`wb_stb_i`/`wb_addr_i`/`wb_we_i`/`wb_dat_i`/`wb_sel_i`/`wb_cti_i` and consumes `wb_ack_o`/`wb_dat_o`. It sits between the testbench or user traffic generator and the controller, and is reused as the bus-functional driver in verification.

---
 rtl/wb_burst_master_if.sv | 27 ++
 rtl/wb_burst_master.sv | 149 ++++++++++++++
 tb/tb_wb_burst_master.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_if.sv
// Wishbone bus bundle between wb_burst_master and the SDRAM controller port.
// Names follow the slave's view: *_i flows into the slave, *_o out of it.
interface wb_burst_master_if #(
    parameter int dw = 32
) ();
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic            wb_we_i;
    logic [25:0]     wb_addr_i;
    logic [dw-1:0]   wb_dat_i;
    logic [dw/8-1:0] wb_sel_i;
    logic [2:0]      wb_cti_i;
    logic [dw-1:0]   wb_dat_o;
    logic            wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i,
        output wb_dat_i, wb_sel_i, wb_cti_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i,
        input  wb_dat_i, wb_sel_i, wb_cti_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_burst_master.sv
// Command/data stream to Wishbone classic + incrementing-burst initiator.
// Write data passes through a one-word holding register (wb_dat_i itself).
module wb_burst_master #(
    parameter int dw   = 32,
    parameter int BL_W = 3,
    parameter int TMO  = 255
) (
    input  logic            sys_clk,
    input  logic            RESET,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [25:0]     cmd_addr,
    input  logic            cmd_we,
    input  logic [BL_W-1:0] cmd_len,
    input  logic [dw/8-1:0] cmd_sel,
    input  logic [dw-1:0]   wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [dw-1:0]   rd_data,
    output logic            rd_valid,
    output logic            done,
    output logic            err_tmo,
    wb_burst_master_if.master wb
);
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t          state;
    logic [BL_W-1:0] len;
    logic [BL_W-1:0] cnt;
    logic [BL_W:0]   ld;
    logic [TW-1:0]   tmo_cnt;
    logic            full;

    logic            ack_hit;
    logic            last;
    logic            fire;
    logic            full_n;
    logic            tmo_hit;
    logic            end_bus;
    logic [BL_W-1:0] cnt_nxt;

    // wr_ready may rise in the ack cycle so a held wr_valid streams 1 beat/cycle
    always_comb begin
        ack_hit  = wb.wb_stb_i & wb.wb_ack_o;
        last     = (cnt == len);
        cnt_nxt  = cnt + 1'b1;
        wr_ready = (state == BUS) & wb.wb_we_i
                 & ({1'b0, len} >= ld) & (~full | ack_hit);
        fire     = wr_valid & wr_ready;
        full_n   = fire | (full & ~ack_hit);
        tmo_hit  = wb.wb_stb_i & ~wb.wb_ack_o
                 & (tmo_cnt == TW'(TMO - 1));
        end_bus  = tmo_hit | (ack_hit & last);
    end

    always_ff @(posedge sys_clk) begin
        if (RESET) begin
            state        <= IDLE;
            cmd_ready    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            done         <= 1'b0;
            err_tmo      <= 1'b0;
            len          <= '0;
            cnt          <= '0;
            ld           <= '0;
            tmo_cnt      <= '0;
            full         <= 1'b0;
            wb.wb_cyc_i  <= 1'b0;
            wb.wb_stb_i  <= 1'b0;
            wb.wb_we_i   <= 1'b0;
            wb.wb_addr_i <= '0;
            wb.wb_dat_i  <= '0;
            wb.wb_sel_i  <= '0;
            wb.wb_cti_i  <= '0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err_tmo  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state        <= BUS;
                        cmd_ready    <= 1'b0;
                        len          <= cmd_len;
                        cnt          <= '0;
                        ld           <= '0;
                        tmo_cnt      <= '0;
                        full         <= 1'b0;
                        wb.wb_addr_i <= cmd_addr;
                        wb.wb_we_i   <= cmd_we;
                        wb.wb_sel_i  <= cmd_sel;
                        wb.wb_cti_i  <= (cmd_len == '0) ? 3'b000 : 3'b010;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                BUS: begin
                    if (fire) begin
                        wb.wb_dat_i <= wr_data;
                        ld          <= ld + 1'b1;
                    end
                    full <= full_n;
                    if (wb.wb_stb_i && !wb.wb_ack_o) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (ack_hit) begin
                        tmo_cnt      <= '0;
                        cnt          <= cnt_nxt;
                        wb.wb_addr_i <= wb.wb_addr_i + 1'b1;
                        wb.wb_cti_i  <= (cnt_nxt == len) ? 3'b111 : 3'b010;
                        if (!wb.wb_we_i) begin
                            rd_data  <= wb.wb_dat_o;
                            rd_valid <= 1'b1;
                        end
                    end
                    wb.wb_cyc_i <= 1'b1;
                    wb.wb_stb_i <= wb.wb_we_i ? full_n : 1'b1;
                    if (tmo_hit) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        err_tmo   <= 1'b1;
                    end else if (ack_hit && last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                    // leaving the bus: drop everything, discard held word
                    if (end_bus) begin
                        full         <= 1'b0;
                        wb.wb_cyc_i  <= 1'b0;
                        wb.wb_stb_i  <= 1'b0;
                        wb.wb_we_i   <= 1'b0;
                        wb.wb_addr_i <= '0;
                        wb.wb_dat_i  <= '0;
                        wb.wb_sel_i  <= '0;
                        wb.wb_cti_i  <= '0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: directed scenarios plus random bursts
// against a memory-based reference model and a configurable Wishbone slave.
module tb_wb_burst_master;
    localparam int DW  = 32;
    localparam int BLW = 3;
    localparam int TMO = 16;

    logic          sys_clk = 1'b0;
    logic          RESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [25:0]   cmd_addr = '0;
    logic          cmd_we = 1'b0;
    logic [BLW-1:0] cmd_len = '0;
    logic [3:0]    cmd_sel = '0;
    logic [31:0]   wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          done;
    logic          err_tmo;

    always #5 sys_clk = ~sys_clk;

    wb_burst_master_if #(.dw(DW)) wb ();

    wb_burst_master #(.dw(DW), .BL_W(BLW), .TMO(TMO)) dut (
        .sys_clk(sys_clk), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_we(cmd_we),
        .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err_tmo(err_tmo),
        .wb(wb)
    );

    typedef struct {
        logic [25:0] a;
        logic        we;
        logic [31:0] d;
        logic [3:0]  sel;
        logic [2:0]  cti;
    } beat_t;

    int checks = 0;
    int errors = 0;

    beat_t       exp_beats[$];
    logic [31:0] exp_rd[$];
    int          exp_end[$];   // 1 = done, 2 = timeout
    logic [31:0] model_mem[logic [25:0]];
    logic [31:0] slave_mem[logic [25:0]];
    logic [31:0] wq[$];
    int          wgap[$];
    logic [31:0] wbuf[8];
    int          gbuf[8];

    int mode = 0;   // slave: 0 zero-wait, 1 ack every 3rd, 2 never, 3 random
    int cyc_no = 0;
    int acc_c = 0;
    int n_acks = 0, n_rdv = 0, n_stb = 0, n_gap = 0;
    int last_stb_c = 0, last_rdv_c = 0, last_done_c = 0;
    logic [1:0] tmo_bus = 2'b11;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(logic [25:0] a);
        return {a, 6'b0} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                          logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ctrl_outs();
        return 64'({cmd_ready, wr_ready, rd_valid, done, err_tmo,
                    wb.wb_cyc_i, wb.wb_stb_i, wb.wb_we_i, wb.wb_cti_i,
                    wb.wb_sel_i, wb.wb_addr_i});
    endfunction

    always @(posedge sys_clk) cyc_no++;

    // Wishbone slave: decides ack/data just after each edge
    initial begin
        int wc;
        wc = 0;
        wb.wb_ack_o = 1'b0;
        wb.wb_dat_o = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (wb.wb_cyc_i && wb.wb_stb_i && !RESET) begin
                case (mode)
                    0: wb.wb_ack_o = 1'b1;
                    1: begin
                        wb.wb_ack_o = (wc == 2);
                        wc = (wc == 2) ? 0 : wc + 1;
                    end
                    2: wb.wb_ack_o = 1'b0;
                    default: wb.wb_ack_o = ($urandom_range(0, 3) != 0);
                endcase
            end else begin
                wb.wb_ack_o = 1'b0;
                wc = 0;
            end
            wb.wb_dat_o = slave_mem.exists(wb.wb_addr_i) ?
                          slave_mem[wb.wb_addr_i] : dflt(wb.wb_addr_i);
        end
    end

    // Write-data source: one word per handshake, optional idle gap per word
    initial begin
        bit pend;
        pend = 0;
        forever begin
            @(negedge sys_clk);
            if (pend && wq.size() > 0) begin
                void'(wq.pop_front());
                void'(wgap.pop_front());
            end
            if (wq.size() > 0 && wgap[0] > 0) begin
                wgap[0] = wgap[0] - 1;
                wr_valid = 1'b0;
            end else if (wq.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wq[0];
            end else begin
                wr_valid = 1'b0;
            end
            pend = wr_valid && wr_ready;
        end
    end

    // Monitor / scoreboard
    always @(negedge sys_clk) begin
        beat_t b;
        int k;
        if (wb.wb_stb_i) begin
            n_stb++;
            last_stb_c = cyc_no;
        end
        if (wb.wb_cyc_i && !wb.wb_stb_i) n_gap++;
        if (wb.wb_stb_i && wb.wb_ack_o) begin
            n_acks++;
            if (wb.wb_we_i)
                slave_mem[wb.wb_addr_i] = merge(
                    slave_mem.exists(wb.wb_addr_i) ? slave_mem[wb.wb_addr_i]
                                                   : dflt(wb.wb_addr_i),
                    wb.wb_dat_i, wb.wb_sel_i);
            if (exp_beats.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected addr %h", wb.wb_addr_i);
            end else begin
                b = exp_beats.pop_front();
                chk("beat_cyc_we_cti_sel_addr",
                    64'({wb.wb_cyc_i, wb.wb_we_i, wb.wb_cti_i,
                         wb.wb_sel_i, wb.wb_addr_i}),
                    64'({1'b1, b.we, b.cti, b.sel, b.a}));
                if (b.we) chk("beat_wdata", 64'(wb.wb_dat_i), 64'(b.d));
            end
        end
        if (rd_valid) begin
            n_rdv++;
            last_rdv_c = cyc_no;
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected data %h", rd_data);
            end else begin
                chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
            end
        end
        if (done || err_tmo) begin
            k = done ? (err_tmo ? 3 : 1) : 2;
            if (done) last_done_c = cyc_no;
            if (err_tmo) tmo_bus = {wb.wb_cyc_i, wb.wb_stb_i};
            if (exp_end.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL end_unexpected kind %0d", k);
            end else begin
                chk("end_kind", 64'(k), 64'(exp_end.pop_front()));
            end
        end
    end

    task automatic flush();
        exp_beats.delete();
        exp_rd.delete();
        exp_end.delete();
        wq.delete();
        wgap.delete();
    endtask

    // Reference model: expected beats/read data/ending from the command alone
    task automatic issue(logic [25:0] a, logic we, logic [2:0] len,
                         logic [3:0] sel, bit tmo);
        beat_t b;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge sys_clk);
        chk("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        for (int i = 0; i <= int'(len) && !tmo; i++) begin
            b.a   = a + 26'(i);
            b.we  = we;
            b.sel = sel;
            b.d   = we ? wbuf[i] : '0;
            b.cti = (len == 0) ? 3'b000 : (i == int'(len)) ? 3'b111 : 3'b010;
            exp_beats.push_back(b);
            if (we) begin
                model_mem[b.a] = merge(model_mem.exists(b.a) ?
                                       model_mem[b.a] : dflt(b.a),
                                       wbuf[i], sel);
                wq.push_back(wbuf[i]);
                wgap.push_back(gbuf[i]);
            end else begin
                exp_rd.push_back(model_mem.exists(b.a) ?
                                 model_mem[b.a] : dflt(b.a));
            end
        end
        exp_end.push_back(tmo ? 2 : 1);
        cmd_addr  = a;
        cmd_we    = we;
        cmd_len   = len;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        acc_c     = cyc_no;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(string name);
        for (int i = 0; i < 3000 && exp_end.size() != 0; i++)
            @(negedge sys_clk);
        if (exp_end.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_no_end pending %0d", name, exp_end.size());
        end
        chk({name, "_drained"}, 64'(exp_beats.size() + exp_rd.size()), 64'd0);
        flush();
        @(negedge sys_clk);
    endtask

    initial begin
        int s0, r0, a0, g0;
        logic [25:0] ra;
        for (int i = 0; i < 8; i++) gbuf[i] = 0;

        repeat (3) @(negedge sys_clk);
        chk("reset_ctrl", ctrl_outs(), 64'd0);
        chk("reset_data", {rd_data, wb.wb_dat_i}, 64'd0);
        RESET = 1'b0;
        @(negedge sys_clk);
        chk("reset_cmd_ready_after", 64'(cmd_ready), 64'd1);

        // single classic read, zero-wait
        mode = 0;
        slave_mem[26'h100] = 32'hCAFE_F00D;
        model_mem[26'h100] = 32'hCAFE_F00D;
        s0 = n_stb;
        issue(26'h100, 1'b0, 3'd0, 4'hF, 1'b0);
        wait_end("single");
        chk("single_stb_cycles", 64'(n_stb - s0), 64'd1);
        chk("single_rdv_after_ack", 64'(last_rdv_c - last_stb_c), 64'd1);
        chk("single_done_with_rdv", 64'(last_done_c), 64'(last_rdv_c));
        chk("single_done_latency", 64'(last_done_c - acc_c), 64'd3);
        chk("single_cmd_ready", 64'(cmd_ready), 64'd1);

        // 8-beat write across the address wrap
        for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
        s0 = n_stb;
        issue(26'h3FF_FFFE, 1'b1, 3'd7, 4'hF, 1'b0);
        wait_end("wr8");
        chk("wr8_stb_cycles", 64'(n_stb - s0), 64'd8);

        // read the same burst back with random slave wait states
        mode = 3;
        issue(26'h3FF_FFFE, 1'b0, 3'd7, 4'hF, 1'b0);
        wait_end("rd8_back");

        // 4-beat write with a 3-cycle wr_valid gap before beat 3
        mode = 0;
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        gbuf[2] = 3;
        g0 = n_gap;
        issue(26'h0000_200, 1'b1, 3'd3, 4'hF, 1'b0);
        wait_end("wr_gap");
        gbuf[2] = 0;
        chk("wr_gap_stb_low_cyc_high", 64'((n_gap - g0) >= 3), 64'd1);

        // 4-beat read, ack every third stb cycle
        mode = 1;
        r0 = n_rdv;
        a0 = n_acks;
        issue(26'h0000_200, 1'b0, 3'd3, 4'hF, 1'b0);
        wait_end("ws");
        chk("ws_rdv_count", 64'(n_rdv - r0), 64'd4);
        chk("ws_ack_count", 64'(n_acks - a0), 64'd4);

        // timeout: ack never arrives
        mode = 2;
        s0 = n_stb;
        issue(26'h0000_300, 1'b0, 3'd1, 4'hF, 1'b1);
        wait_end("tmo");
        chk("tmo_stb_cycles", 64'(n_stb - s0), 64'(TMO));
        chk("tmo_bus_dropped", 64'(tmo_bus), 64'd0);
        chk("tmo_cmd_ready", 64'(cmd_ready), 64'd1);

        // reset during an 8-beat read
        mode = 0;
        a0 = n_acks;
        issue(26'h0000_400, 1'b0, 3'd7, 4'hF, 1'b0);
        for (int i = 0; i < 100 && (n_acks - a0) < 3; i++)
            @(negedge sys_clk);
        chk("rst_mid_reached_beat3", 64'((n_acks - a0) >= 3), 64'd1);
        RESET = 1'b1;
        @(negedge sys_clk);
        chk("rst_mid_ctrl", ctrl_outs(), 64'd0);
        chk("rst_mid_data", {rd_data, wb.wb_dat_i}, 64'd0);
        RESET = 1'b0;
        flush();
        @(negedge sys_clk);
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);

        // random traffic against the reference model
        mode = 3;
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 1) == 0) ?
                 26'($urandom_range(0, 31)) :
                 26'h3FF_FFF0 + 26'($urandom_range(0, 15));
            for (int i = 0; i < 8; i++) begin
                wbuf[i] = $urandom;
                gbuf[i] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0;
            end
            issue(ra, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)), 1'b0);
            wait_end("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
